// File: rtl/cla_adder_arbiter_if.sv
// Bus bundle for cla_adder_arbiter.
// Purpose : groups the per-requester operand channel, the result channel and
//           the accepted-request counter into one interface.
// Signals : req_valid/req_ready/req_a/req_b  - requester side, packed per index
//           rsp_valid/rsp_ready/rsp_sum/rsp_cout/rsp_id - result channel
//           busy_cnt - running count of accepted requests
// Modports: master (requesters + consumer), slave (the arbiter/adder).
interface cla_adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [IDW-1:0]           rsp_id;
  logic [15:0]              busy_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy_cnt
  );
endinterface

// File: rtl/cla_adder_arbiter.sv
// cla_adder_arbiter
// Purpose : shares one WIDTH-bit carry-lookahead adder between NUM_REQ
//           requesters using round-robin arbitration, with a single
//           registered result stage on a valid/ready response channel.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - cla_adder_arbiter_if.slave (operands in, result out,
//                   accepted-request counter out)
module cla_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_adder_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [IDW-1:0]   grant_s;
  logic             any_valid_s;
  logic             accept_s;
  logic             xfer_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH:0]   add_s;

  // Generate/propagate carry chain; result is {carry out of MSB, sum}.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    g    = a & b;
    p    = a | b;
    s    = '0;
    c    = '0;
    c[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      s[i]   = a[i] ^ b[i] ^ c[i];
    end
    return {c[WIDTH], s};
  endfunction

  // Requester index at a given offset from the round-robin pointer, wrapping.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int             offset);
    int idx_v;
    idx_v = (int'(base) + offset) % NUM_REQ;
    return IDW'(idx_v);
  endfunction

  // Round-robin grant: scanning offsets from farthest to nearest makes the
  // nearest valid requester at or after rr_ptr the final winner.
  always_comb begin
    grant_s     = rr_ptr_q;
    any_valid_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_index(rr_ptr_q, k)]) begin
        grant_s     = rr_index(rr_ptr_q, k);
        any_valid_s = 1'b1;
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s == IDW'(i)) begin
        op_a_s = bus.req_a[i*WIDTH +: WIDTH];
        op_b_s = bus.req_b[i*WIDTH +: WIDTH];
      end else begin
        op_a_s = op_a_s;
      end
    end
  end

  assign add_s    = cla_add(op_a_s, op_b_s);
  // The result slot is free when empty or when it drains this very cycle.
  assign accept_s = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign xfer_s   = accept_s && any_valid_s && rst_n;

  // One-hot ready toward the winner; held low while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if (xfer_s) begin
      bus.req_ready[grant_s] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
  end

  // Next-state and datapath load decisions for the result stage.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    if (xfer_s) begin
      sum_d    = add_s[WIDTH-1:0];
      cout_d   = add_s[WIDTH];
      id_d     = grant_s;
      cnt_d    = cnt_q + 16'd1;
      rr_ptr_d = (grant_s == IDW'(NUM_REQ - 1)) ? '0 : grant_s + IDW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      ST_EMPTY: state_d = xfer_s ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (xfer_s) begin
          state_d = ST_FULL;
        end else if (bus.rsp_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      id_q     <= '0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy_cnt  = cnt_q;
endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Testbench for cla_adder_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the arbiter.
module tb_cla_adder_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam logic [N*W-1:0] LANE = {{((N-1)*W){1'b0}}, {W{1'b1}}};

  logic clk;
  logic rst_n;

  cla_adder_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) ifc ();

  cla_adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the single result slot and the arbitration pointer.
  bit          m_valid;
  logic [W-1:0] m_sum;
  logic        m_cout;
  int          m_id;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [N-1:0] last_ready;
  int          n_xfer;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.req_a = (ifc.req_a & ~(LANE << (i * W))) | ((N*W)'(a) << (i * W));
    ifc.req_b = (ifc.req_b & ~(LANE << (i * W))) | ((N*W)'(b) << (i * W));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 16'd0;
    last_ready = '0;
  endtask

  // Compare everything at the falling edge, then advance the model at the rising edge.
  task automatic cycle_check();
    logic [N-1:0] exp_ready;
    logic [W-1:0] a_v, b_v;
    logic [W:0]   full;
    int g;
    @(negedge clk);
    g = pick(ifc.req_valid, m_ptr);
    exp_ready = '0;
    if (g >= 0 && (!m_valid || ifc.rsp_ready)) exp_ready[g] = 1'b1;
    check_eq("req_ready", 64'(ifc.req_ready), 64'(exp_ready));
    check_eq("rsp_valid", 64'(ifc.rsp_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("rsp_sum", 64'(ifc.rsp_sum), 64'(m_sum));
      check_eq("rsp_cout", 64'(ifc.rsp_cout), 64'(m_cout));
      check_eq("rsp_id", 64'(ifc.rsp_id), 64'(m_id));
    end
    check_eq("busy_cnt", 64'(ifc.busy_cnt), 64'(m_cnt));
    a_v = '0; b_v = '0;
    if (g >= 0) begin
      a_v = W'(ifc.req_a >> (g * W));
      b_v = W'(ifc.req_b >> (g * W));
    end
    last_ready = exp_ready;
    @(posedge clk);
    if (exp_ready != '0) begin
      full    = {1'b0, a_v} + {1'b0, b_v};
      m_sum   = full[W-1:0];
      m_cout  = full[W];
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
      m_cnt   = m_cnt + 16'd1;
      n_xfer++;
    end else if (m_valid && ifc.rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Assert reset away from the clock edge, check it takes effect at once, release idle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check_eq("rst_busy_cnt", 64'(ifc.busy_cnt), 64'd0);
    check_eq("rst_req_ready", 64'(ifc.req_ready), 64'd0);
    check_eq("rst_rsp_sum", 64'(ifc.rsp_sum), 64'd0);
    check_eq("rst_rsp_id", 64'(ifc.rsp_id), 64'd0);
    model_reset();
    ifc.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] hold_sum;
    int hold_id;
    rst_n         = 1'b0;
    ifc.req_valid = '1;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.rsp_ready = 1'b0;
    n_xfer        = 0;
    #3;
    do_reset();

    // Basic add on requester 0, one-cycle latency.
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 4'b0001;
    set_req(0, 32'h0000_0005, 32'h0000_0003);
    cycle_check();
    ifc.req_valid = '0;
    check_eq("t1_valid", 64'(ifc.rsp_valid), 64'd1);
    check_eq("t1_sum", 64'(ifc.rsp_sum), 64'h8);
    check_eq("t1_cout", 64'(ifc.rsp_cout), 64'd0);
    check_eq("t1_id", 64'(ifc.rsp_id), 64'd0);

    // Carry-out boundaries.
    ifc.req_valid = 4'b0001;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001);
    cycle_check();
    check_eq("t2a_sum", 64'(ifc.rsp_sum), 64'h0);
    check_eq("t2a_cout", 64'(ifc.rsp_cout), 64'd1);
    set_req(0, 32'h8000_0000, 32'h8000_0000);
    cycle_check();
    ifc.req_valid = '0;
    check_eq("t2b_sum", 64'(ifc.rsp_sum), 64'h0);
    check_eq("t2b_cout", 64'(ifc.rsp_cout), 64'd1);
    cycle_check();

    // All requesters valid: strict rotation, one grant per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
    ifc.req_valid = '1;
    ifc.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle_check();
      check_eq("t3_id", 64'(ifc.rsp_id), 64'(k % N));
    end
    check_eq("t3_busy", 64'(ifc.busy_cnt), 64'd5);

    // Backpressure: result frozen, nobody accepted, rotation resumes after.
    hold_sum = ifc.rsp_sum;
    hold_id  = int'(ifc.rsp_id);
    ifc.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle_check();
      check_eq("t4_sum_hold", 64'(ifc.rsp_sum), 64'(hold_sum));
      check_eq("t4_id_hold", 64'(ifc.rsp_id), 64'(hold_id));
      check_eq("t4_ready_low", 64'(ifc.req_ready), 64'd0);
    end
    ifc.rsp_ready = 1'b1;
    cycle_check();
    check_eq("t4_next_id", 64'(ifc.rsp_id), 64'((hold_id + 1) % N));
    cycle_check();

    // Reset mid-stream; arbitration restarts at the lowest valid index.
    #2;
    do_reset();
    ifc.req_valid = 4'b1100;
    cycle_check();
    check_eq("t5_first_id", 64'(ifc.rsp_id), 64'd2);
    ifc.req_valid = '0;
    cycle_check();

    // Randomized traffic under random backpressure.
    n_xfer = 0;
    for (int cyc = 0; cyc < 60000 && n_xfer < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!ifc.req_valid[i] || last_ready[i]) begin
          ifc.req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, rand_op(), rand_op());
        end
      end
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle_check();
    end
    check_eq("rand_xfer_done", 64'(n_xfer >= 10000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
